masked_xor_compress: RTL and testbench

Parametrised, pipelined share-compression tree for the Boolean-masking datapath. It folds `N_SHARES` Boolean shares of a `K_WIDTH`-bit value into `OUT_SHARES` shares, one tree layer per cycle, with a ring refresh on every layer. The XOR of the output shares always equals the XOR of the input shares. It generalises the fixed 8-to-1 full XOR unmasker: share count is arbitrary (not only powers of two), the output share count is selectable so it can act as a partial compressor ahead of B2A conversion, and randomness is consumed per layer.

---
 rtl/masked_xor_compress_if.sv | 20 ++
 rtl/masked_xor_compress.sv | 110 +++++++++++
 tb/tb_masked_xor_compress.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/masked_xor_compress_if.sv
// Share-compression bus: input shares plus fresh randomness in, compressed shares out.
// Valid-only transfer: dvld qualifies i_x and ovld qualifies o_z. There is no ready; ena is a global advance.
interface masked_xor_compress_if #(
  parameter int K_WIDTH    = 32,
  parameter int N_SHARES   = 8,
  parameter int OUT_SHARES = 1
);
  localparam int RANDNUM   = N_SHARES - OUT_SHARES;
  localparam int RND_WORDS = (RANDNUM > 0) ? RANDNUM : 1;

  logic                            ena;
  logic                            dvld;
  logic [N_SHARES*K_WIDTH-1:0]     i_x;
  logic [RND_WORDS*K_WIDTH-1:0]    rnd;
  logic [OUT_SHARES*K_WIDTH-1:0]   o_z;
  logic                            ovld;

  modport master (output ena, dvld, i_x, rnd, input o_z, ovld);
  modport slave  (input ena, dvld, i_x, rnd, output o_z, ovld);
endinterface

// File: rtl/masked_xor_compress.sv
// Pipelined Boolean-share compression tree with ring refresh on every layer.
// The XOR of o_z equals the XOR of i_x, and each layer register holds one tree level.
module masked_xor_compress #(
  parameter int K_WIDTH    = 32,
  parameter int N_SHARES   = 8,
  parameter int OUT_SHARES = 1
) (
  input logic                 clk,
  input logic                 rst,
  masked_xor_compress_if.slave bus
);
  localparam int RANDNUM   = N_SHARES - OUT_SHARES;
  localparam int RND_WORDS = (RANDNUM > 0) ? RANDNUM : 1;
  localparam int W         = N_SHARES * K_WIDTH;

  function automatic int merges(int n);
    int half;
    int rem;
    half = n / 2;
    rem  = n - OUT_SHARES;
    return (half < rem) ? half : rem;
  endfunction

  function automatic int layer_n(int l);
    int n;
    n = N_SHARES;
    for (int i = 0; i < N_SHARES; i++) begin
      if (i < l) n = n - merges(n);
    end
    return n;
  endfunction

  function automatic int calc_layers();
    int n;
    int cnt;
    n   = N_SHARES;
    cnt = 0;
    if (N_SHARES == OUT_SHARES) return 1;
    for (int i = 0; i < N_SHARES; i++) begin
      if (n > OUT_SHARES) begin
        n   = n - merges(n);
        cnt = cnt + 1;
      end
    end
    return cnt;
  endfunction

  localparam int LAYERS = calc_layers();

  logic [W-1:0]        data_q   [LAYERS];
  logic [LAYERS-1:0]   vld_q;
  logic [W-1:0]        layer_in [LAYERS];
  logic [W-1:0]        nxt      [LAYERS];
  logic [K_WIDTH-1:0]  s        [N_SHARES];
  logic [K_WIDTH-1:0]  c        [N_SHARES];
  logic [K_WIDTH-1:0]  r        [RND_WORDS];
  int                  n;
  int                  m;
  int                  off;

  always_comb begin
    n   = N_SHARES;
    m   = 0;
    off = 0;
    for (int w = 0; w < RND_WORDS; w++) r[w] = bus.rnd[w*K_WIDTH +: K_WIDTH];
    layer_in[0] = bus.i_x;
    for (int l = 1; l < LAYERS; l++) layer_in[l] = data_q[l-1];

    for (int l = 0; l < LAYERS; l++) begin
      n   = layer_n(l);
      m   = (N_SHARES == OUT_SHARES) ? 0 : merges(n);
      // Words consumed by earlier layers equal the share reduction so far.
      off = N_SHARES - n;
      for (int i = 0; i < N_SHARES; i++) begin
        s[i] = layer_in[l][i*K_WIDTH +: K_WIDTH];
        c[i] = '0;
      end
      for (int j = 0; j < N_SHARES / 2; j++) begin
        if (j < m) begin
          c[j] = s[2*j] ^ s[2*j+1] ^ r[off+j];
          if (j > 0) c[j] = c[j] ^ r[off+j-1];
        end
      end
      for (int k = 0; k < N_SHARES; k++) begin
        if (k >= 2*m && k < n) c[k-m] = s[k];
      end
      // Close the ring: last word lands on the first pass-through share, else wraps to c0.
      if (m > 0) begin
        if (n > 2*m) c[m] = c[m] ^ r[off+m-1];
        else         c[0] = c[0] ^ r[off+m-1];
      end
      nxt[l] = '0;
      for (int i = 0; i < N_SHARES; i++) nxt[l][i*K_WIDTH +: K_WIDTH] = c[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LAYERS; l++) data_q[l] <= '0;
      vld_q <= '0;
    end else if (bus.ena) begin
      for (int l = 0; l < LAYERS; l++) data_q[l] <= nxt[l];
      vld_q[0] <= bus.dvld;
      for (int l = 1; l < LAYERS; l++) vld_q[l] <= vld_q[l-1];
    end
  end

  assign bus.o_z  = data_q[LAYERS-1][OUT_SHARES*K_WIDTH-1:0];
  assign bus.ovld = vld_q[LAYERS-1];
endmodule

// File: tb/tb_masked_xor_compress.sv
// Bench for masked_xor_compress: three configurations (8->1, 5->2, 4->4) driven in lockstep
// and checked every cycle against a share-list model of the layer rules.
module tb_masked_xor_compress;
  typedef struct packed {
    logic         v;
    logic [511:0] x;
    logic [511:0] r;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena_d  [3];
  logic         dvld_d [3];
  logic [511:0] x_d    [3];
  logic [511:0] r_d    [3];
  rec_t         h0[$];
  rec_t         h1[$];
  rec_t         h2[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cfg_n   [3] = '{8, 5, 4};
  int           cfg_out [3] = '{1, 2, 4};
  int           cfg_l   [3] = '{3, 2, 1};
  logic [127:0] deg_val;

  always #5 clk = ~clk;

  masked_xor_compress_if #(.K_WIDTH(32), .N_SHARES(8), .OUT_SHARES(1)) b0 ();
  masked_xor_compress_if #(.K_WIDTH(32), .N_SHARES(5), .OUT_SHARES(2)) b1 ();
  masked_xor_compress_if #(.K_WIDTH(32), .N_SHARES(4), .OUT_SHARES(4)) b2 ();

  assign b0.ena = ena_d[0];  assign b0.dvld = dvld_d[0];
  assign b0.i_x = x_d[0][255:0];  assign b0.rnd = r_d[0][223:0];
  assign b1.ena = ena_d[1];  assign b1.dvld = dvld_d[1];
  assign b1.i_x = x_d[1][159:0];  assign b1.rnd = r_d[1][95:0];
  assign b2.ena = ena_d[2];  assign b2.dvld = dvld_d[2];
  assign b2.i_x = x_d[2][127:0];  assign b2.rnd = r_d[2][31:0];

  masked_xor_compress #(.K_WIDTH(32), .N_SHARES(8), .OUT_SHARES(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  masked_xor_compress #(.K_WIDTH(32), .N_SHARES(5), .OUT_SHARES(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  masked_xor_compress #(.K_WIDTH(32), .N_SHARES(4), .OUT_SHARES(4)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // Folds the share list layer by layer exactly as the layer rules describe.
  function automatic logic [511:0] model(int n_sh, int out_sh, logic [511:0] x, logic [3:0][511:0] rl);
    logic [31:0]  s[$];
    logic [31:0]  c[$];
    logic [31:0]  w;
    logic [511:0] res;
    int           n, m, off, lay;
    for (int i = 0; i < n_sh; i++) s.push_back(x[i*32 +: 32]);
    off = 0;
    lay = 0;
    do begin
      n = s.size();
      m = (n / 2 < n - out_sh) ? n / 2 : n - out_sh;
      c.delete();
      for (int j = 0; j < m; j++) begin
        w = s[2*j] ^ s[2*j+1] ^ rl[lay][(off+j)*32 +: 32];
        if (j > 0) w = w ^ rl[lay][(off+j-1)*32 +: 32];
        c.push_back(w);
      end
      for (int k = 2*m; k < n; k++) c.push_back(s[k]);
      if (m > 0) begin
        w = rl[lay][(off+m-1)*32 +: 32];
        if (n - 2*m > 0) c[m] = c[m] ^ w;
        else             c[0] = c[0] ^ w;
      end
      s   = c;
      off = off + m;
      lay = lay + 1;
    end while (s.size() > out_sh);
    res = '0;
    for (int i = 0; i < s.size(); i++) res[i*32 +: 32] = s[i];
    return res;
  endfunction

  function automatic rec_t get_rec(int d, int i);
    case (d)
      0:       return h0[i];
      1:       return h1[i];
      default: return h2[i];
    endcase
  endfunction

  function automatic int hsize(int d);
    case (d)
      0:       return h0.size();
      1:       return h1.size();
      default: return h2.size();
    endcase
  endfunction

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(int d, logic [511:0] oz, logic ov);
    int               cnt;
    int               e;
    rec_t             rc;
    logic [3:0][511:0] rl;
    logic [511:0]     exp;
    logic [31:0]      xi;
    logic [31:0]      xo;
    cnt = hsize(d);
    if (cnt == 0) begin
      check($sformatf("d%0d_reset_oz", d), oz, '0);
      check($sformatf("d%0d_reset_ovld", d), {511'b0, ov}, '0);
    end else if (cnt < cfg_l[d]) begin
      check($sformatf("d%0d_fill_ovld", d), {511'b0, ov}, '0);
    end else begin
      e  = cnt - cfg_l[d];
      rc = get_rec(d, e);
      check($sformatf("d%0d_ovld_e%0d", d, e), {511'b0, ov}, {511'b0, rc.v});
      if (rc.v) begin
        rl = '0;
        for (int l = 0; l < cfg_l[d]; l++) rl[l] = get_rec(d, e + l).r;
        exp = model(cfg_n[d], cfg_out[d], rc.x, rl);
        check($sformatf("d%0d_oz_e%0d", d, e), oz, exp);
        xi = '0;
        xo = '0;
        for (int i = 0; i < cfg_n[d]; i++) xi = xi ^ rc.x[i*32 +: 32];
        for (int i = 0; i < cfg_out[d]; i++) xo = xo ^ oz[i*32 +: 32];
        check($sformatf("d%0d_xor_e%0d", d, e), {480'b0, xo}, {480'b0, xi});
      end
    end
  endtask

  task automatic rand_in(int d);
    for (int w = 0; w < 16; w++) begin
      x_d[d][w*32 +: 32] = $urandom();
      r_d[d][w*32 +: 32] = $urandom();
    end
  endtask

  task automatic set_all(logic en, logic dv);
    for (int d = 0; d < 3; d++) begin
      ena_d[d]  = en;
      dvld_d[d] = dv;
      rand_in(d);
    end
  endtask

  // Records what each DUT samples on the coming edge, then checks after it.
  task automatic tick();
    rec_t rc;
    for (int d = 0; d < 3; d++) begin
      rc.v = dvld_d[d];
      rc.x = x_d[d];
      rc.r = r_d[d];
      if (rst) begin
        case (d)
          0: h0.delete();
          1: h1.delete();
          default: h2.delete();
        endcase
      end else if (ena_d[d]) begin
        case (d)
          0: h0.push_back(rc);
          1: h1.push_back(rc);
          default: h2.push_back(rc);
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_dut(0, {256'b0, b0.o_z}, b0.ovld);
    check_dut(1, {448'b0, b1.o_z}, b1.ovld);
    check_dut(2, {384'b0, b2.o_z}, b2.ovld);
  endtask

  initial begin
    rst = 1'b1;
    set_all(1'b1, 1'b1);
    tick();
    set_all(1'b1, 1'b1);
    tick();

    // Directed transfers right after reset release.
    rst = 1'b0;
    set_all(1'b1, 1'b1);
    x_d[0] = '0;
    for (int i = 0; i < 8; i++) x_d[0][i*32 +: 32] = 32'h1 << i;
    x_d[1] = '0;
    x_d[1][159:0] = {32'hF0, 32'h88, 32'h44, 32'h22, 32'h11};
    r_d[1][95:0]  = {3{32'h0000000F}};
    deg_val = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    x_d[2] = {384'b0, deg_val};
    tick();
    check("deg_passthru", {384'b0, b2.o_z}, {384'b0, deg_val});
    set_all(1'b1, 1'b0);
    r_d[1][95:0] = {3{32'h0000000F}};
    tick();
    check("part_5to2_fixed_rnd", {448'b0, b1.o_z}, {448'b0, 32'h000000F0, 32'h000000FF});
    set_all(1'b1, 1'b0);
    tick();
    check("unmask_onehot", {480'b0, b0.o_z}, {480'b0, 32'h000000FF});
    check("unmask_onehot_ovld", {511'b0, b0.ovld}, {511'b0, 1'b1});

    // Back-to-back random vectors.
    for (int t = 0; t < 1000; t++) begin
      set_all(1'b1, 1'b1);
      tick();
    end

    // Mixed enable and valid.
    for (int t = 0; t < 300; t++) begin
      for (int d = 0; d < 3; d++) begin
        ena_d[d]  = ($urandom_range(0, 9) != 0);
        dvld_d[d] = ($urandom_range(0, 3) != 0);
        rand_in(d);
      end
      tick();
    end

    // Four-cycle stall while inputs keep toggling.
    for (int t = 0; t < 6; t++) begin set_all(1'b1, 1'b1); tick(); end
    for (int t = 0; t < 4; t++) begin set_all(1'b0, 1'($urandom_range(0, 1))); tick(); end
    for (int t = 0; t < 6; t++) begin set_all(1'b1, 1'b1); tick(); end

    // Bubble pattern 1,0,1,1,0.
    set_all(1'b1, 1'b1); tick();
    set_all(1'b1, 1'b0); tick();
    set_all(1'b1, 1'b1); tick();
    set_all(1'b1, 1'b1); tick();
    set_all(1'b1, 1'b0); tick();
    for (int t = 0; t < 4; t++) begin set_all(1'b1, 1'b0); tick(); end

    // Reset with three transfers in flight.
    for (int t = 0; t < 3; t++) begin set_all(1'b1, 1'b1); tick(); end
    rst = 1'b1;
    set_all(1'b1, 1'b1);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin set_all(1'b1, 1'b0); tick(); end
    for (int t = 0; t < 4; t++) begin set_all(1'b1, 1'b1); tick(); end
    for (int t = 0; t < 4; t++) begin set_all(1'b1, 1'b0); tick(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
